// File: rtl/adder_accum_pkg.sv
// Shared types and helpers for the adder_accum frame accumulator.
package adder_accum_pkg;

  localparam int SAMPLE_W = 17;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  // Beat counter only needs to hold 0..count-1.
  function automatic int cnt_width(input int count);
    return (count <= 2) ? 1 : $clog2(count);
  endfunction

endpackage

// File: rtl/adder_accum_if.sv
// Valid/ready bus between the adder stage, the accumulator and its consumer.
interface adder_accum_if #(
  parameter int ACC_W = 20
);

  logic             in_valid;
  logic             in_ready;
  logic [15:0]      sum_in;
  logic             cout_in;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] acc_out;
  logic             ovf_out;

  modport master (
    output in_valid, sum_in, cout_in, out_ready,
    input  in_ready, out_valid, acc_out, ovf_out
  );

  modport slave (
    input  in_valid, sum_in, cout_in, out_ready,
    output in_ready, out_valid, acc_out, ovf_out
  );

endinterface

// File: rtl/acc_add_sat.sv
// ACC_W-bit accumulate step with carry-out detection.
// Define ADDER_ACCUM_SATURATE_EN to clamp at 2^ACC_W-1 instead of wrapping.
module acc_add_sat
  import adder_accum_pkg::*;
#(
  parameter int ACC_W = 20
) (
  input  logic [ACC_W-1:0]    acc,
  input  logic [SAMPLE_W-1:0] sample,
  output logic [ACC_W-1:0]    sum,
  output logic                carry
);

  logic [ACC_W:0] wide;

  // One extra bit catches the carry beyond ACC_W.
  assign wide  = {1'b0, acc} + (ACC_W + 1)'(sample);
  assign carry = wide[ACC_W];

`ifdef ADDER_ACCUM_SATURATE_EN
  // Once clamped, any further non-zero sample carries again and re-clamps.
  assign sum = carry ? '1 : wide[ACC_W-1:0];
`else
  assign sum = wide[ACC_W-1:0];
`endif

endmodule

// File: rtl/adder_accum.sv
// Sums COUNT 17-bit adder results per frame and presents the total on a valid/ready output.
// Optional clamp on overflow via ADDER_ACCUM_SATURATE_EN (see acc_add_sat).
module adder_accum
  import adder_accum_pkg::*;
#(
  parameter int COUNT = 4,
  parameter int ACC_W = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  adder_accum_if.slave  bus
);

  localparam int               CNT_W = cnt_width(COUNT);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(COUNT - 1);

  state_t              state;
  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    acc_next;
  logic [CNT_W-1:0]    cnt;
  logic                ovf;
  logic                carry;
  logic [SAMPLE_W-1:0] sample;

  assign sample = {bus.cout_in, bus.sum_in};

  acc_add_sat #(
    .ACC_W (ACC_W)
  ) u_add (
    .acc    (acc),
    .sample (sample),
    .sum    (acc_next),
    .carry  (carry)
  );

  assign bus.in_ready  = (state == ACCUM) && !clear;
  assign bus.out_valid = (state == DONE);
  assign bus.acc_out   = acc;
  assign bus.ovf_out   = ovf;

  // NOTE: sequential state uses non-blocking assignments so every register
  // in this block updates from pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACCUM;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else if (clear) begin
      // Abort wins over any beat or result handshake in the same cycle.
      state <= ACCUM;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      unique case (state)
        ACCUM: begin
          if (bus.in_valid) begin
            acc <= acc_next;
            ovf <= ovf | carry;
            if (cnt == LAST) begin
              cnt   <= '0;
              state <= DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state <= ACCUM;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_accum.sv
// Directed scoreboard bench for adder_accum: default instance plus an ACC_W=18 overflow instance.
module tb_adder_accum;

  typedef struct packed {
    logic [19:0] acc;
    logic        ovf;
  } exp_t;

`ifdef ADDER_ACCUM_SATURATE_EN
  localparam logic [17:0] EXP18_B3 = 18'h3FFFF;
  localparam logic [17:0] EXP18_B4 = 18'h3FFFF;
`else
  localparam logic [17:0] EXP18_B3 = 18'h1FFFD;
  localparam logic [17:0] EXP18_B4 = 18'h3FFFC;
`endif

  logic clk = 1'b0;
  logic rst;
  logic clear;
  logic clear18;
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  adder_accum_if #(.ACC_W(20)) bus ();
  adder_accum_if #(.ACC_W(18)) bus18 ();

  adder_accum #(.COUNT(4), .ACC_W(20)) dut (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .bus   (bus)
  );

  adder_accum #(.COUNT(4), .ACC_W(18)) dut18 (
    .clk   (clk),
    .rst   (rst),
    .clear (clear18),
    .bus   (bus18)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until the DUT takes it (bounded).
  task automatic send_beat(input logic [16:0] s);
    int waited = 0;
    bus.in_valid = 1'b1;
    {bus.cout_in, bus.sum_in} = s;
    #1;
    while (!bus.in_ready && waited < 50) begin
      tick();
      waited++;
    end
    if (!bus.in_ready) check("beat_accept_timeout", bus.in_ready, 1);
    else tick();
    bus.in_valid = 1'b0;
  endtask

  // Wait for a frame result, compare against the scoreboard, then handshake it.
  task automatic expect_frame(input string tag);
    exp_t e;
    int   waited = 0;
    while (!bus.out_valid && waited < 50) begin
      tick();
      waited++;
    end
    check({tag, "_valid"}, bus.out_valid, 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_acc"}, bus.acc_out, e.acc);
      check({tag, "_ovf"}, bus.ovf_out, e.ovf);
    end else begin
      check({tag, "_scoreboard"}, 64'(sb.size()), 1);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, "_released"}, bus.out_valid, 0);
  endtask

  initial begin
    logic [16:0] frame_a [4];
    logic [16:0] s;
    longint      model;

    frame_a[0] = 17'h0FFFF;
    frame_a[1] = 17'h0F4D5;
    frame_a[2] = 17'h03E5F;
    frame_a[3] = 17'h02C3F;

    rst = 1'b1;
    clear = 1'b0;
    clear18 = 1'b0;
    bus.in_valid = 1'b0;
    bus.sum_in = '0;
    bus.cout_in = 1'b0;
    bus.out_ready = 1'b0;
    bus18.in_valid = 1'b0;
    bus18.sum_in = '0;
    bus18.cout_in = 1'b0;
    bus18.out_ready = 1'b0;

    // Reset state.
    #12;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_acc", bus.acc_out, 0);
    check("rst_ovf", bus.ovf_out, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("rst_in_ready", bus.in_ready, 1);

    // Back-to-back frame; out_valid must rise right after the 4th handshake.
    sb.push_back('{acc: 20'h25F72, ovf: 1'b0});
    for (int i = 0; i < 4; i++) begin
      send_beat(frame_a[i]);
      check($sformatf("b2b_out_valid_%0d", i), bus.out_valid, (i == 3));
    end

    // Stall the result for 10 cycles while upstream offers the next beat.
    bus.in_valid = 1'b1;
    {bus.cout_in, bus.sum_in} = frame_a[0];
    for (int i = 0; i < 10; i++) begin
      #1;
      check($sformatf("hold_acc_%0d", i), bus.acc_out, 20'h25F72);
      check($sformatf("hold_in_ready_%0d", i), bus.in_ready, 0);
      tick();
    end
    expect_frame("hold");

    // Offered beat is taken on the cycle after the release; rest of frame is gapped.
    sb.push_back('{acc: 20'h25F72, ovf: 1'b0});
    check("post_release_in_ready", bus.in_ready, 1);
    send_beat(frame_a[0]);
    check("gap_live_acc", bus.acc_out, 20'h0FFFF);
    for (int i = 1; i < 4; i++) begin
      tick();
      tick();
      check($sformatf("gap_no_valid_%0d", i), bus.out_valid, 0);
      send_beat(frame_a[i]);
    end
    expect_frame("gapped");

    // Asynchronous reset mid-frame discards the partial sum.
    send_beat(17'h09999);
    send_beat(17'h09999);
    check("pre_rst_live_acc", bus.acc_out, 20'h13332);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_acc", bus.acc_out, 0);
    check("async_rst_out_valid", bus.out_valid, 0);
    #1;
    rst = 1'b0;
    tick();
    sb.push_back('{acc: 20'h26664, ovf: 1'b0});
    for (int i = 0; i < 4; i++) send_beat(17'h09999);
    expect_frame("after_rst");

    // Clear alongside the 3rd beat drops it and restarts the count.
    send_beat(17'h05555);
    send_beat(17'h05555);
    bus.in_valid = 1'b1;
    {bus.cout_in, bus.sum_in} = 17'h05555;
    clear = 1'b1;
    #1;
    check("clear_in_ready", bus.in_ready, 0);
    tick();
    clear = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("clear_acc", bus.acc_out, 0);
    sb.push_back('{acc: 20'h00004, ovf: 1'b0});
    for (int i = 0; i < 4; i++) send_beat(17'h00001);
    expect_frame("after_clear");

    // Clear in DONE beats a concurrent output handshake; the result is dropped.
    for (int i = 0; i < 4; i++) send_beat(17'h00010);
    check("clear_done_valid", bus.out_valid, 1);
    clear = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    clear = 1'b0;
    bus.out_ready = 1'b0;
    check("clear_done_dropped", bus.out_valid, 0);
    check("clear_done_acc", bus.acc_out, 0);

    // Random frames against a wide software sum.
    for (int f = 0; f < 3; f++) begin
      exp_t e;
      model = 0;
      for (int i = 0; i < 4; i++) begin
        s = 17'($urandom_range(0, 17'h1FFFF));
        model += longint'(s);
        send_beat(s);
      end
      e.acc = model[19:0];
      e.ovf = (model >= 64'h100000);
      sb.push_back(e);
      expect_frame($sformatf("rand_%0d", f));
    end

    // ACC_W=18: four {1,FFFF} beats overflow on the 3rd beat.
    bus18.in_valid = 1'b1;
    {bus18.cout_in, bus18.sum_in} = 17'h1FFFF;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("w18_in_ready_%0d", i), bus18.in_ready, 1);
      tick();
      if (i == 1) begin
        check("w18_b2_acc", bus18.acc_out, 18'h3FFFE);
        check("w18_b2_ovf", bus18.ovf_out, 0);
      end
      if (i == 2) begin
        check("w18_b3_acc", bus18.acc_out, EXP18_B3);
        check("w18_b3_ovf", bus18.ovf_out, 1);
      end
    end
    bus18.in_valid = 1'b0;
    check("w18_out_valid", bus18.out_valid, 1);
    check("w18_acc", bus18.acc_out, EXP18_B4);
    check("w18_ovf", bus18.ovf_out, 1);
    bus18.out_ready = 1'b1;
    tick();
    bus18.out_ready = 1'b0;
    check("w18_next_acc", bus18.acc_out, 0);
    check("w18_next_ovf", bus18.ovf_out, 0);

    check("scoreboard_drained", 64'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adder_accum.md
ADDER_ACCUM -- requirements
Module: adder_accum

Interface
REQ-001 Parameter COUNT, default 4, number of adder results summed per frame (range 2..255).
REQ-002 Parameter ACC_W, default 20, accumulator and result width in bits (range 17..32).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 clear  input  1  synchronous frame abort and restart.
REQ-006 in_valid  input  1  upstream adder result valid.
REQ-007 in_ready  output  1  block accepts a result this cycle.
REQ-008 sum_in  input  16  sum word from the 16-bit adder stage.
REQ-009 cout_in  input  1  adder carry-out (MSB of the adder c_out vector), weight 2^16.
REQ-010 out_valid  output  1  frame result valid.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 acc_out  output  ACC_W  frame sum.
REQ-013 ovf_out  output  1  frame overflowed ACC_W (sticky within the frame).

Function
REQ-014 Each accepted beat contributes the 17-bit unsigned sample {cout_in, sum_in}, zero-extended to ACC_W.
REQ-015 FSM has two states, ACCUM and DONE; in_ready = (state==ACCUM) && !clear; out_valid = (state==DONE).
REQ-016 In ACCUM, a beat is accepted when in_valid && in_ready; acc <= acc + sample and beat count increments.
REQ-017 On the COUNT-th accepted beat, the FSM enters DONE; out_valid rises the next cycle (latency 1 cycle after last handshake).
REQ-018 In DONE, acc_out and ovf_out hold stable until out_valid && out_ready; input beats are not accepted.
REQ-019 On the DONE handshake, the FSM returns to ACCUM with acc=0, count=0, ovf=0; a new beat can be accepted the following cycle.
REQ-020 The carry out of acc + sample beyond ACC_W sets ovf for the frame; ovf never clears until the frame ends.
REQ-021 acc_out is the live accumulator in ACCUM and is valid only while out_valid=1.
REQ-022 clear=1 in any state forces ACCUM, acc=0, count=0, ovf=0 next cycle; it overrides any concurrent input or output handshake, and that beat/result is dropped.
REQ-023 in_valid while in_ready=0 has no effect; upstream holds data per valid/ready rules.

Reset
REQ-024 rst=1 immediately forces state=ACCUM, acc=0, count=0, ovf=0, out_valid=0, acc_out=0, ovf_out=0; in_ready=1 once rst and clear are low.
REQ-025 Reset mid-frame discards partial sums; there is no resume.

Configuration
REQ-026 Macro ADDER_ACCUM_SATURATE_EN defined: on overflow acc clamps to 2^ACC_W-1 and stays there for the frame; ovf_out=1.
REQ-027 Macro undefined: acc wraps modulo 2^ACC_W; ovf_out=1 as per REQ-020.

Structure
REQ-028 Package adder_accum_pkg holds the state enum (ACCUM, DONE), SAMPLE_W=17, and the beat-count width function.
REQ-029 Sub-module acc_add_sat holds the ACC_W adder, overflow detection and optional clamp; the top holds FSM, counter and handshake.

Verification
REQ-030 Frame of 4: (F0F0+0F0F)={0,FFFF}, {0,F4D5}, {0,3E5F}, {0,2C3F} back-to-back -> out_valid one cycle after 4th beat, acc_out=0x25F72, ovf_out=0.
REQ-031 out_ready held 0 for 10 cycles in DONE -> acc_out stays 0x25F72, in_ready=0 throughout; on out_ready=1 the next cycle accepts a beat.
REQ-032 ACC_W=18, 4 beats of {1,FFFF}: without SATURATE_EN -> acc_out=0x3FFFC, ovf_out=1; with it -> acc_out=0x3FFFF, ovf_out=1.
REQ-033 rst pulsed after 2 beats -> acc_out=0, out_valid=0 asynchronously; next 4 beats {0,9999} -> acc_out=0x26664.
REQ-034 clear asserted together with the 3rd in_valid -> beat not accepted (in_ready=0), count restarts; 4 further beats of {0,0001} -> acc_out=0x00004.
REQ-035 Gapped in_valid (1 of every 3 cycles) over 4 beats -> same result as REQ-030, out_valid only after the 4th handshake.
